led_share_arbiter: RTL and testbench

Shares the 4-LED bank between three requesters with round-robin arbitration and a fixed display hold time. When no requester owns the bank, it drives a rotating one-hot chase pattern. It sits between the board LED pins and the display producers: counter readout, key feedback and status. It replaces per-producer direct LED drive.

---
 rtl/led_share_arbiter_if.sv | 15 +
 rtl/led_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_led_share_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_share_arbiter_if.sv
// Handshake and display bus between the LED producers and the LED share arbiter.
`timescale 1ns/1ps
interface led_share_arbiter_if;
  logic [2:0] req;
  logic [3:0] pat0;
  logic [3:0] pat1;
  logic [3:0] pat2;
  logic [2:0] gnt;
  logic       done;
  logic       busy;
  logic [3:0] led;

  modport master (output req, pat0, pat1, pat2, input gnt, done, busy, led);
  modport slave  (input req, pat0, pat1, pat2, output gnt, done, busy, led);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 4-LED bank between three producers, with a
// one-hot chase pattern shown whenever nobody owns the bank.
`timescale 1ns/1ps
module led_share_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd12_500_000,
  parameter int unsigned STEP_CYCLES = 32'd12_500_000
) (
  input logic              clk,
  input logic              rst_n,
  led_share_arbiter_if.slave bus
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 32'd1);
  localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  led_r, led_s;
  logic [2:0]  gnt_r, gnt_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;
  logic [1:0]  idx_r, idx_s;
  logic [31:0] step_cnt_r, step_cnt_s;
  logic [31:0] hold_cnt_r, hold_cnt_s;
  logic [1:0]  rr_r, rr_s;
  logic [3:0]  pat_r, pat_s;

  logic        win_valid_s;
  logic [1:0]  win_idx_s;
  logic [3:0]  win_pat_s;
  logic        take_grant_s;

  function automatic logic [1:0] rr_candidate(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  function automatic logic [3:0] chase_pattern(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Round-robin search: walk offsets 3..1 so the nearest requester after rr overwrites last.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      if (bus.req[rr_candidate(rr_r, 2'(k))]) begin
        win_valid_s = 1'b1;
        win_idx_s   = rr_candidate(rr_r, 2'(k));
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Pattern offered by the current arbitration winner.
  always_comb begin
    case (win_idx_s)
      2'd0:    win_pat_s = bus.pat0;
      2'd1:    win_pat_s = bus.pat1;
      2'd2:    win_pat_s = bus.pat2;
      default: win_pat_s = 4'b0000;
    endcase
  end

  // Next-state and output decode; a grant from IDLE or RELEASE overrides the per-state result.
  always_comb begin
    state_s      = state_r;
    led_s        = led_r;
    gnt_s        = gnt_r;
    done_s       = 1'b0;
    busy_s       = busy_r;
    idx_s        = idx_r;
    step_cnt_s   = step_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    rr_s         = rr_r;
    pat_s        = pat_r;
    take_grant_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        led_s        = chase_pattern(idx_r);
        gnt_s        = 3'b000;
        busy_s       = 1'b0;
        take_grant_s = win_valid_s;
        if (step_cnt_r == STEP_LAST) begin
          step_cnt_s = 32'd0;
          idx_s      = idx_r + 2'd1;
        end else begin
          step_cnt_s = step_cnt_r + 32'd1;
        end
      end
      ST_SHOW: begin
        led_s = pat_r;
        if (hold_cnt_r == HOLD_LAST) begin
          state_s    = ST_RELEASE;
          gnt_s      = 3'b000;
          done_s     = 1'b1;
          led_s      = 4'b0000;
          busy_s     = 1'b1;
          hold_cnt_s = 32'd0;
        end else begin
          hold_cnt_s = hold_cnt_r + 32'd1;
        end
      end
      ST_RELEASE: begin
        state_s      = ST_IDLE;
        led_s        = chase_pattern(idx_r);
        gnt_s        = 3'b000;
        busy_s       = 1'b0;
        take_grant_s = win_valid_s;
      end
      default: begin
        state_s = ST_IDLE;
        led_s   = 4'b0000;
        gnt_s   = 3'b000;
        busy_s  = 1'b0;
      end
    endcase

    if (take_grant_s) begin
      state_s    = ST_SHOW;
      rr_s       = win_idx_s;
      gnt_s      = 3'b001 << win_idx_s;
      pat_s      = win_pat_s;
      led_s      = win_pat_s;
      hold_cnt_s = 32'd0;
      busy_s     = 1'b1;
      done_s     = 1'b0;
    end else begin
      rr_s = rr_s;
    end
  end

  // State and output registers; reset discards any latched pattern without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      led_r      <= 4'b0000;
      gnt_r      <= 3'b000;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      idx_r      <= 2'd0;
      step_cnt_r <= 32'd0;
      hold_cnt_r <= 32'd0;
      rr_r       <= 2'd2;
      pat_r      <= 4'b0000;
    end else begin
      state_r    <= state_s;
      led_r      <= led_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      idx_r      <= idx_s;
      step_cnt_r <= step_cnt_s;
      hold_cnt_r <= hold_cnt_s;
      rr_r       <= rr_s;
      pat_r      <= pat_s;
    end
  end

  assign bus.led  = led_r;
  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_led_share_arbiter;

  localparam int HOLD = 4;
  localparam int STEP = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   chk_en;

  led_share_arbiter_if bus ();

  led_share_arbiter #(.HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 show, 2 release; chase position derived from total idle ticks.
  int         m_state;
  int         m_ticks;
  int         m_shown;
  int         m_rr;
  logic [3:0] m_pat;
  logic [3:0] m_led;
  logic [2:0] m_gnt;
  logic       m_done;
  logic       m_busy;

  function automatic logic [3:0] pick_pat(input int w, input logic [3:0] p0,
                                          input logic [3:0] p1, input logic [3:0] p2);
    if (w == 0) return p0;
    if (w == 1) return p1;
    return p2;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_ticks = 0; m_shown = 0; m_rr = 2; m_pat = 4'b0000;
        m_led = 4'b0000; m_gnt = 3'b000; m_done = 1'b0; m_busy = 1'b0;
      end else begin
        int win;
        win = -1;
        if (m_state != 1) begin
          for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_rr + k) % 3;
            if (bus.req[c] && win < 0) win = c;
          end
        end
        m_done = 1'b0;
        if (m_state == 0) begin
          m_led = 4'b0001 << ((m_ticks / STEP) % 4);
          m_ticks = m_ticks + 1;
        end else if (m_state == 1) begin
          if (m_shown == HOLD - 1) begin
            m_state = 2; m_led = 4'b0000; m_gnt = 3'b000; m_done = 1'b1; m_busy = 1'b1;
          end else begin
            m_shown = m_shown + 1;
          end
        end else begin
          m_state = 0; m_gnt = 3'b000; m_busy = 1'b0;
          m_led = 4'b0001 << ((m_ticks / STEP) % 4);
        end
        if (win >= 0) begin
          m_state = 1; m_rr = win; m_gnt = 3'b001 << win; m_shown = 0; m_busy = 1'b1;
          m_pat = pick_pat(win, bus.pat0, bus.pat1, bus.pat2);
          m_led = m_pat; m_done = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_led",  {4'b0, bus.led},  {4'b0, m_led});
        chk("model_gnt",  {5'b0, bus.gnt},  {5'b0, m_gnt});
        chk("model_done", {7'b0, bus.done}, {7'b0, m_done});
        chk("model_busy", {7'b0, bus.busy}, {7'b0, m_busy});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] chase_exp [13];

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    rst_n = 1'b1;
    bus.req = 3'b000; bus.pat0 = 4'b0000; bus.pat1 = 4'b0000; bus.pat2 = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset then 13 idle cycles of chase.
    cyc(); cyc();
    chk("reset_led", {4'b0, bus.led}, 8'h00);
    chk("reset_busy", {7'b0, bus.busy}, 8'h00);
    rst_n = 1'b1;
    chase_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("chase_led", {4'b0, bus.led}, {4'b0, chase_exp[i]});
      chk("chase_gnt", {5'b0, bus.gnt}, 8'h00);
    end

    // Single request from requester 1.
    bus.req = 3'b010; bus.pat1 = 4'b1010;
    cyc();
    bus.req = 3'b000;
    for (int i = 0; i < HOLD; i++) begin
      if (i > 0) cyc();
      chk("single_gnt", {5'b0, bus.gnt}, 8'h02);
      chk("single_led", {4'b0, bus.led}, 8'h0a);
    end
    cyc();
    chk("single_blank", {4'b0, bus.led}, 8'h00);
    chk("single_done", {7'b0, bus.done}, 8'h01);
    cyc();
    chk("single_resume", {4'b0, bus.led}, 8'h01);
    chk("single_done_low", {7'b0, bus.done}, 8'h00);

    // Round robin after reset with all requesters active.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.req = 3'b111; bus.pat0 = 4'b0001; bus.pat1 = 4'b0010; bus.pat2 = 4'b0100;
    for (int w = 0; w < 4; w++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (w % 3);
      for (int i = 0; i < HOLD; i++) begin
        cyc();
        chk("rr_gnt", {5'b0, bus.gnt}, exp_g);
        chk("rr_led", {4'b0, bus.led}, exp_g);
      end
      cyc();
      chk("rr_blank", {4'b0, bus.led}, 8'h00);
      chk("rr_done", {7'b0, bus.done}, 8'h01);
      if (w == 3) bus.req = 3'b000;
    end
    cyc();

    // Pattern changes after the grant edge are ignored.
    bus.req = 3'b001; bus.pat0 = 4'b1111;
    cyc();
    bus.req = 3'b000; bus.pat0 = 4'b0000;
    for (int i = 0; i < HOLD; i++) begin
      if (i > 0) cyc();
      chk("stable_led", {4'b0, bus.led}, 8'h0f);
    end
    cyc(); cyc();

    // Reset during the second SHOW cycle.
    bus.req = 3'b001; bus.pat0 = 4'b0110;
    cyc();
    bus.req = 3'b000;
    cyc();
    chk("pre_rst_led", {4'b0, bus.led}, 8'h06);
    rst_n = 1'b0;
    #1;
    chk("midrst_led", {4'b0, bus.led}, 8'h00);
    chk("midrst_gnt", {5'b0, bus.gnt}, 8'h00);
    chk("midrst_busy", {7'b0, bus.busy}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_done", {7'b0, bus.done}, 8'h00);
    end
    rst_n = 1'b1;
    cyc();
    chk("postrst_chase", {4'b0, bus.led}, 8'h01);
    bus.req = 3'b101; bus.pat0 = 4'b0011; bus.pat2 = 4'b1100;
    cyc();
    chk("postrst_tie", {5'b0, bus.gnt}, 8'h01);

    // Request arriving during the last SHOW cycle is granted straight out of RELEASE.
    bus.req = 3'b000;
    for (int i = 1; i < HOLD; i++) cyc();
    bus.req = 3'b100; bus.pat2 = 4'b1001;
    cyc();
    chk("rel_blank", {4'b0, bus.led}, 8'h00);
    cyc();
    chk("rel_gnt", {5'b0, bus.gnt}, 8'h04);
    chk("rel_led", {4'b0, bus.led}, 8'h09);
    bus.req = 3'b000;

    // Randomized traffic, occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) bus.req = bus.req & ~bus.gnt;
      bus.pat0 = 4'($urandom_range(0, 15));
      bus.pat1 = 4'($urandom_range(0, 15));
      bus.pat2 = 4'($urandom_range(0, 15));
    end
    rst_n = 1'b1;
    cyc(); cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
